// File: rtl/pre_mem_stage.sv
// pre_mem_stage: pipeline register between EX and MEM.
// - Latches EX results and issues the data-SRAM request (req/addr_ok) for
//   loads and stores, exactly once per instruction.
// - Builds store byte strobes and replicated write data.
// - Reports the accepting cycle of a request to MEM via pms_req_ok.
// Build option: define PMS_ALIGN_CHECK_EN to raise AdEL/AdES on misaligned
// accesses. Without it the access address is forced aligned instead.
module pre_mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              ms_allowin,
  output logic              pms_allowin,
  input  logic              es_valid,
  input  logic [31:0]       es_pc,
  input  logic [ADDR_W-1:0] es_addr,
  input  logic              es_re,
  input  logic              es_we,
  input  logic [1:0]        es_size,
  input  logic [DATA_W-1:0] es_sdata,
  input  logic [4:0]        es_dest,
  input  logic              es_ex,
  input  logic [4:0]        es_excode,
  output logic              pms_valid_out,
  output logic [31:0]       pms_pc,
  output logic [ADDR_W-1:0] pms_result,
  output logic              pms_res_from_mem,
  output logic              pms_res_to_mem,
  output logic [4:0]        pms_dest,
  output logic              pms_ex,
  output logic [4:0]        pms_excode,
  output logic [ADDR_W-1:0] pms_badvaddr,
  output logic              pms_req_ok,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok
);

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  logic              valid_q;
  logic              req_done_q, req_done_d;
  logic [31:0]       pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic              re_q, we_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] sdata_q;
  logic [4:0]        dest_q;
  logic              ex_q;
  logic [4:0]        excode_q;

  logic              mem;
  logic              align_err;
  logic              ex_all;
  logic              ready_go;
  logic              leave;
  logic [ADDR_W-1:0] addr_al;
  logic [3:0]        wstrb_raw;

  // Alignment check / forced alignment of the access address
  always_comb begin
    align_err = 1'b0;
    addr_al   = addr_q;
`ifdef PMS_ALIGN_CHECK_EN
    align_err = (re_q | we_q) &
                (((size_q == 2'd1) & addr_q[0]) |
                 (size_q[1] & (addr_q[1:0] != 2'b00)));
`else
    if (size_q == 2'd1) begin
      addr_al[0] = 1'b0;
    end else if (size_q[1]) begin
      addr_al[1:0] = 2'b00;
    end
`endif
  end

  assign mem      = (re_q | we_q) & valid_q;
  assign ex_all   = ex_q | align_err;
  assign data_req = mem & ~ex_all & ~req_done_q & ~flush;
  assign pms_req_ok = data_req & data_addr_ok;
  assign ready_go = ~mem | ex_all | req_done_q | pms_req_ok;
  assign leave    = ready_go & ms_allowin;
  assign pms_allowin   = ~valid_q | leave;
  assign pms_valid_out = valid_q & ready_go;

  // Request-done flag: remembers an accepted request while MEM stalls us
  always_comb begin
    req_done_d = req_done_q;
    if (flush || leave) begin
      req_done_d = 1'b0;
    end else if (pms_req_ok) begin
      req_done_d = 1'b1;
    end
  end

  // Stage valid and request-done state
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q    <= 1'b0;
      req_done_q <= 1'b0;
    end else begin
      req_done_q <= req_done_d;
      if (pms_allowin) begin
        valid_q <= es_valid;
      end
    end
  end

  // Payload latch from EX
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      addr_q   <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= '0;
      sdata_q  <= '0;
      dest_q   <= '0;
      ex_q     <= 1'b0;
      excode_q <= '0;
    end else if (es_valid && pms_allowin && !flush) begin
      pc_q     <= es_pc;
      addr_q   <= es_addr;
      re_q     <= es_re;
      we_q     <= es_we;
      size_q   <= es_size;
      sdata_q  <= es_sdata;
      dest_q   <= es_dest;
      ex_q     <= es_ex;
      excode_q <= es_excode;
    end
  end

  // Store strobes and lane-replicated write data
  always_comb begin
    wstrb_raw  = 4'b1111;
    data_wdata = sdata_q;
    case (size_q)
      2'd0: begin
        wstrb_raw  = 4'b0001 << addr_al[1:0];
        data_wdata = {4{sdata_q[7:0]}};
      end
      2'd1: begin
        wstrb_raw  = addr_al[1] ? 4'b1100 : 4'b0011;
        data_wdata = {2{sdata_q[15:0]}};
      end
      default: begin
        wstrb_raw  = 4'b1111;
        data_wdata = sdata_q;
      end
    endcase
  end

  // Exception code: upstream code wins, own AdEL/AdES otherwise, 0 when clean
  always_comb begin
    pms_excode = '0;
    if (ex_q) begin
      pms_excode = excode_q;
    end else if (align_err) begin
      pms_excode = re_q ? EXC_ADEL : EXC_ADES;
    end
  end

  assign data_wstrb       = we_q ? wstrb_raw : 4'b0000;
  assign data_wr          = we_q;
  assign data_size        = size_q;
  assign data_addr        = addr_al;
  assign pms_pc           = pc_q;
  assign pms_result       = addr_q;
  assign pms_badvaddr     = addr_q;
  assign pms_dest         = dest_q;
  assign pms_res_from_mem = re_q & valid_q;
  assign pms_res_to_mem   = we_q & valid_q;
  assign pms_ex           = ex_all & valid_q;

endmodule

// File: tb/tb_pre_mem_stage.sv
// Testbench for pre_mem_stage: directed vectors plus a per-cycle comparison
// against a behavioural model of the stage.
`timescale 1ns/1ps
module tb_pre_mem_stage;

  logic        clk = 1'b0;
  logic        reset, flush, ms_allowin, pms_allowin;
  logic        es_valid, es_re, es_we, es_ex;
  logic [31:0] es_pc, es_addr, es_sdata;
  logic [1:0]  es_size;
  logic [4:0]  es_dest, es_excode;
  logic        pms_valid_out, pms_res_from_mem, pms_res_to_mem, pms_ex, pms_req_ok;
  logic [31:0] pms_pc, pms_result, pms_badvaddr;
  logic [4:0]  pms_dest, pms_excode;
  logic        data_req, data_wr, data_addr_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;

  int n_checks = 0;
  int n_fail   = 0;
  int n_reqok  = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  pre_mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .ms_allowin(ms_allowin),
    .pms_allowin(pms_allowin), .es_valid(es_valid), .es_pc(es_pc),
    .es_addr(es_addr), .es_re(es_re), .es_we(es_we), .es_size(es_size),
    .es_sdata(es_sdata), .es_dest(es_dest), .es_ex(es_ex), .es_excode(es_excode),
    .pms_valid_out(pms_valid_out), .pms_pc(pms_pc), .pms_result(pms_result),
    .pms_res_from_mem(pms_res_from_mem), .pms_res_to_mem(pms_res_to_mem),
    .pms_dest(pms_dest), .pms_ex(pms_ex), .pms_excode(pms_excode),
    .pms_badvaddr(pms_badvaddr), .pms_req_ok(pms_req_ok), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          allowin, valid_out, req, req_ok, ex;
    bit          res_from, res_to, wr;
    logic [4:0]  excode, dest;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] pc, result, addr, wdata;
  } exp_t;

  bit          m_valid = 0, m_issued = 0;
  logic [31:0] m_pc = 0, m_addr = 0, m_sdata = 0;
  bit          m_re = 0, m_we = 0, m_ex = 0;
  logic [1:0]  m_size = 0;
  logic [4:0]  m_dest = 0, m_excode = 0;

  function automatic exp_t model_out();
    exp_t        e;
    int unsigned nbytes;
    bit          mem_op, mis, exc, done;
    logic [31:0] a;
    logic [7:0]  strb;
    nbytes = (m_size == 0) ? 1 : (m_size == 1) ? 2 : 4;
    mem_op = m_re || m_we;
`ifdef PMS_ALIGN_CHECK_EN
    mis = mem_op && ((m_addr % nbytes) != 0);
    a   = m_addr;
`else
    mis = 1'b0;
    a   = m_addr - (m_addr % nbytes);
`endif
    exc      = m_ex || mis;
    e.req    = m_valid && mem_op && !exc && !m_issued && !flush;
    e.req_ok = e.req && data_addr_ok;
    done     = !(m_valid && mem_op) || exc || m_issued || e.req_ok;
    e.allowin   = !m_valid || (done && ms_allowin);
    e.valid_out = m_valid && done;
    e.ex        = m_valid && exc;
    e.excode    = m_ex ? m_excode : (mis ? (m_re ? 5'h04 : 5'h05) : 5'h00);
    e.res_from  = m_valid && m_re;
    e.res_to    = m_valid && m_we;
    e.wr        = m_we;
    e.size      = m_size;
    e.dest      = m_dest;
    e.pc        = m_pc;
    e.result    = m_addr;
    e.addr      = a;
    strb        = 8'((1 << nbytes) - 1) << (a % 4);
    e.wstrb     = m_we ? strb[3:0] : 4'h0;
    if (nbytes == 1)      e.wdata = (m_sdata % 256) * 32'h01010101;
    else if (nbytes == 2) e.wdata = (m_sdata % 65536) * 32'h00010001;
    else                  e.wdata = m_sdata;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state advance on the active edge
  exp_t ue;
  always @(posedge clk) begin
    if (reset) begin
      m_valid = 0; m_issued = 0; m_pc = 0; m_addr = 0; m_sdata = 0;
      m_re = 0; m_we = 0; m_ex = 0; m_size = 0; m_dest = 0; m_excode = 0;
    end else if (flush) begin
      m_valid = 0; m_issued = 0;
    end else begin
      ue = model_out();
      if (ue.valid_out && ms_allowin) m_issued = 0;
      else if (ue.req_ok)             m_issued = 1;
      if (ue.allowin) begin
        m_valid = es_valid;
        if (es_valid) begin
          m_pc = es_pc; m_addr = es_addr; m_re = es_re; m_we = es_we;
          m_size = es_size; m_sdata = es_sdata; m_dest = es_dest;
          m_ex = es_ex; m_excode = es_excode;
        end
      end
    end
  end

  // Per-cycle compare against the model
  exp_t ce;
  always @(negedge clk) begin
    if (pms_req_ok === 1'b1) n_reqok++;
    if (checking) begin
      ce = model_out();
      chk("allowin",   pms_allowin,      ce.allowin);
      chk("valid_out", pms_valid_out,    ce.valid_out);
      chk("data_req",  data_req,         ce.req);
      chk("req_ok",    pms_req_ok,       ce.req_ok);
      chk("ex",        pms_ex,           ce.ex);
      chk("res_from",  pms_res_from_mem, ce.res_from);
      chk("res_to",    pms_res_to_mem,   ce.res_to);
      if (m_valid) begin
        chk("excode",   pms_excode,   ce.excode);
        chk("pc",       pms_pc,       ce.pc);
        chk("result",   pms_result,   ce.result);
        chk("badvaddr", pms_badvaddr, ce.result);
        chk("dest",     pms_dest,     ce.dest);
        chk("data_wr",  data_wr,      ce.wr);
        chk("size",     data_size,    ce.size);
        chk("addr",     data_addr,    ce.addr);
        chk("wstrb",    data_wstrb,   ce.wstrb);
        chk("wdata",    data_wdata,   ce.wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] addr,
                       input bit re, input bit we, input logic [1:0] size,
                       input logic [31:0] sdata, input bit ex, input logic [4:0] excode);
    es_pc = pc; es_addr = addr; es_re = re; es_we = we; es_size = size;
    es_sdata = sdata; es_dest = pc[6:2]; es_ex = ex; es_excode = excode;
    es_valid = 1'b1;
    step();
    es_valid = 1'b0;
  endtask

  task automatic drain();
    es_valid = 1'b0; flush = 1'b0; ms_allowin = 1'b1; data_addr_ok = 1'b1;
    repeat (3) step();
    look();
    chk("drain_allowin", pms_allowin, 1);
    step();
  endtask

  logic [31:0] t_addr [8] = '{32'h80000100, 32'h80000203, 32'h80000302, 32'h00000042,
                              32'h80000401, 32'h80000500, 32'h80000606, 32'h80000700};
  logic [1:0]  t_size [8] = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd3, 2'd2, 2'd0};
  bit          t_re   [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  bit          t_we   [8] = '{0, 1, 0, 0, 1, 0, 1, 0};
  int          base;

  initial begin
    reset = 1; flush = 0; ms_allowin = 1; data_addr_ok = 0;
    es_valid = 0; es_pc = 0; es_addr = 0; es_re = 0; es_we = 0; es_size = 0;
    es_sdata = 0; es_dest = 0; es_ex = 0; es_excode = 0;
    repeat (2) step();
    look();
    // reset state: everything 0 except pms_allowin
    chk("rst_allowin",  pms_allowin,   1);
    chk("rst_valid",    pms_valid_out, 0);
    chk("rst_req",      data_req,      0);
    chk("rst_excode",   pms_excode,    0);
    chk("rst_pc",       pms_pc,        0);
    chk("rst_addr",     data_addr,     0);
    chk("rst_wdata",    data_wdata,    0);
    chk("rst_wstrb",    data_wstrb,    0);
    step();
    reset = 0;
    checking = 1;

    // word load, addr_ok high: one-cycle pass
    data_addr_ok = 1;
    issue(32'hBFC00000, 32'h80001000, 1, 0, 2'd2, 32'h0, 0, 5'h0);
    look();
    chk("ld_req", data_req, 1);
    chk("ld_reqok", pms_req_ok, 1);
    chk("ld_vout", pms_valid_out, 1);
    chk("ld_from", pms_res_from_mem, 1);
    step();
    look();
    chk("ld_req_after", data_req, 0);
    step();

    // byte store at offset 3
    issue(32'hBFC00004, 32'h80001003, 0, 1, 2'd0, 32'h12345678, 0, 5'h0);
    look();
    chk("sb_wstrb", data_wstrb, 32'h8);
    chk("sb_wdata", data_wdata, 32'h78787878);
    chk("sb_wr", data_wr, 1);
    step();

    // half store, addr_ok arrives in the third cycle
    data_addr_ok = 0;
    issue(32'hBFC00008, 32'h80001002, 0, 1, 2'd1, 32'hCAFEBEEF, 0, 5'h0);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) data_addr_ok = 1;
      look();
      chk("sh_req_held", data_req, 1);
      chk("sh_vout", pms_valid_out, (c == 2) ? 1 : 0);
      chk("sh_wstrb", data_wstrb, 32'hC);
      step();
    end
    look();
    chk("sh_req_done", data_req, 0);
    step();

    // misaligned word load
    issue(32'hBFC0000C, 32'h80001002, 1, 0, 2'd2, 32'h0, 0, 5'h0);
    look();
`ifdef PMS_ALIGN_CHECK_EN
    chk("mis_req", data_req, 0);
    chk("mis_ex", pms_ex, 1);
    chk("mis_excode", pms_excode, 32'h04);
    chk("mis_badv", pms_badvaddr, 32'h80001002);
    chk("mis_vout", pms_valid_out, 1);
`else
    chk("mis_req", data_req, 1);
    chk("mis_ex", pms_ex, 0);
    chk("mis_addr", data_addr, 32'h80001000);
`endif
    step();

    // accepted while MEM stalls for 2 cycles: single request
    drain();
    ms_allowin = 0;
    base = n_reqok;
    issue(32'hBFC00010, 32'h80001004, 1, 0, 2'd2, 32'h0, 0, 5'h0);
    look();
    chk("stl_req0", data_req, 1);
    chk("stl_allow0", pms_allowin, 0);
    step();
    look();
    chk("stl_req1", data_req, 0);
    chk("stl_vout1", pms_valid_out, 1);
    step();
    ms_allowin = 1;
    look();
    chk("stl_allow2", pms_allowin, 1);
    step();
    look();
    chk("stl_reqcount", n_reqok - base, 1);
    step();

    // flush while waiting for addr_ok
    data_addr_ok = 0;
    base = n_reqok;
    issue(32'hBFC00014, 32'h80001008, 1, 0, 2'd2, 32'h0, 0, 5'h0);
    look();
    chk("fl_req0", data_req, 1);
    step();
    flush = 1; data_addr_ok = 1;
    look();
    chk("fl_req", data_req, 0);
    chk("fl_reqok", pms_req_ok, 0);
    step();
    flush = 0;
    look();
    chk("fl_vout", pms_valid_out, 0);
    chk("fl_allow", pms_allowin, 1);
    chk("fl_reqcount", n_reqok - base, 0);
    step();

    // upstream exception on a store: no request
    issue(32'hBFC00018, 32'h80002000, 0, 1, 2'd2, 32'h11111111, 1, 5'h0C);
    look();
    chk("uex_req", data_req, 0);
    chk("uex_ex", pms_ex, 1);
    chk("uex_code", pms_excode, 32'h0C);
    chk("uex_badv", pms_badvaddr, 32'h80002000);
    step();

    // non-memory instruction and reserved size on a store
    issue(32'hBFC0001C, 32'h00001234, 0, 0, 2'd0, 32'h0, 0, 5'h0);
    look();
    chk("alu_vout", pms_valid_out, 1);
    chk("alu_req", data_req, 0);
    chk("alu_result", pms_result, 32'h00001234);
    step();
    issue(32'hBFC00020, 32'h80001000, 0, 1, 2'd3, 32'hA5A51234, 0, 5'h0);
    look();
    chk("sz3_wstrb", data_wstrb, 32'hF);
    chk("sz3_wdata", data_wdata, 32'hA5A51234);
    step();

    // streaming table with varying backpressure and addr_ok
    for (int i = 0; i < 32; i++) begin
      es_valid = (i % 5) != 4;
      es_pc = 32'hBFC01000 + 32'(i * 4);
      es_addr = t_addr[i % 8]; es_re = t_re[i % 8]; es_we = t_we[i % 8];
      es_size = t_size[i % 8]; es_sdata = 32'h01020304 * 32'(i + 1);
      es_dest = 5'(i); es_ex = (i % 11) == 7; es_excode = 5'h0A;
      ms_allowin = (i % 3) != 1;
      data_addr_ok = (i % 4) != 2;
      flush = (i == 23);
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pre_mem_stage.md
Name: pre_mem_stage

Overview:
- Pipeline stage between EX and MEM in the 5+ stage MIPS core.
- Latches EX results and issues the data-SRAM request for loads and stores over a req/addr_ok handshake.
- Builds store byte strobes and replicated write data, and detects misaligned accesses.
- Passes a single-cycle request-accepted flag to MEM so MEM can cancel a response after a flush.

Parameters:
- ADDR_W, 32, data address width.
- DATA_W, 32, data width (only 32 supported).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  exception/eret pipeline flush.
- ms_allowin  in  1  MEM can accept.
- pms_allowin  out  1  this stage can accept.
- es_valid  in  1  EX output valid.
- es_pc  in  32  instruction PC.
- es_addr  in  32  effective address / ALU result.
- es_re  in  1  load.
- es_we  in  1  store.
- es_size  in  2  0 byte, 1 half, 2 word (3 reserved, treated as word).
- es_sdata  in  32  store source register.
- es_dest  in  5  destination register.
- es_ex  in  1  upstream exception pending.
- es_excode  in  5  upstream exception code.
- pms_valid_out  out  1  valid to MEM (valid & ready_go).
- pms_pc  out  32  latched PC.
- pms_result  out  32  latched address/result.
- pms_res_from_mem  out  1  load, gated by valid.
- pms_res_to_mem  out  1  store, gated by valid.
- pms_dest  out  5  latched dest.
- pms_ex  out  1  exception.
- pms_excode  out  5  exception code.
- pms_badvaddr  out  32  faulting address.
- pms_req_ok  out  1  data request accepted this cycle.
- data_req  out  1  request.
- data_wr  out  1  write.
- data_size  out  2  size.
- data_addr  out  32  address.
- data_wstrb  out  4  byte enables.
- data_wdata  out  32  write data.
- data_addr_ok  in  1  request accepted.

Behaviour:
- Reset values: pms_valid=0, req_done=0, all latched fields 0. Every output therefore resets to 0, except pms_allowin=1.
- Stage registers:
  - On reset or flush, pms_valid<=0.
  - Else, if pms_allowin, pms_valid<=es_valid.
  - Payload latches when es_valid && pms_allowin.
  - flush has priority over load.
- mem = (re|we) & pms_valid.
- ex_all = latched es_ex | own alignment error.
- Own alignment error: misaligned when size=1 and addr[0]=1, or size=2 and addr[1:0]!=0.
  - pms_excode = latched excode if es_ex, else AdEL (0x04) for loads, AdES (0x05) for stores.
  - pms_badvaddr = latched addr.
  - pms_ex = ex_all & pms_valid.
- data_req = mem & !ex_all & !req_done & !flush. Purely combinational; no request is ever issued for an excepting instruction.
- pms_req_ok = data_req & data_addr_ok.
- req_done:
  - Set when pms_req_ok && !(ready_go && ms_allowin), i.e. accepted but the stage is stalled.
  - Cleared on reset, flush, or when the instruction leaves the stage (ready_go && ms_allowin).
  - Guarantees exactly one request per instruction.
- ready_go = !mem | ex_all | req_done | pms_req_ok.
- pms_allowin = !pms_valid | (ready_go & ms_allowin).
- Data SRAM fields:
  - data_wr = we.
  - data_size = size.
  - data_addr = addr.
- Store strobes and data:
  - Byte: wstrb = 1<<addr[1:0], wdata = {4{sdata[7:0]}}.
  - Half: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{sdata[15:0]}}.
  - Word: wstrb = 4'b1111, wdata = sdata.
  - Loads: wstrb = 0.
- Flush in the same cycle as an addr_ok handshake: data_req is 0, so no new handshake can start. A handshake already accepted is reported via pms_req_ok in its own cycle, before the flush, and MEM tracks the cancel.
- Latency: non-memory instructions take 1 cycle. Memory instructions take 1 cycle plus the addr_ok wait.

Optional Feature:
- Macro: PMS_ALIGN_CHECK_EN.
- Defined: alignment check and AdEL/AdES generation as above.
- Undefined:
  - No alignment exception; pms_ex reflects only es_ex.
  - data_addr is forced aligned: half clears bit0, word clears bits[1:0].
  - Strobes are computed from the aligned address.

Test Plan:
- Word load 0x80001000, addr_ok held high, ms_allowin=1 -> data_req for 1 cycle, pms_req_ok=1, pms_valid_out same cycle, res_from_mem=1.
- Store byte addr 0x80001003, sdata=0x12345678 -> wstrb=4'b1000, wdata=0x78787878, data_wr=1.
- Half store addr 0x80001002, addr_ok delayed 3 cycles -> data_req held 3 cycles, ready_go low until handshake, single request, wstrb=4'b1100.
- Word load addr 0x80001002 with PMS_ALIGN_CHECK_EN -> no data_req, pms_ex=1, excode=0x04, badvaddr=0x80001002, passes in 1 cycle.
- Handshake accepted while ms_allowin=0 for 2 cycles -> req_done=1, no second data_req; stage advances when ms_allowin=1.
- flush while stalled awaiting addr_ok -> data_req drops the same cycle, pms_valid=0 next cycle, req_done=0, no pms_req_ok.
